// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath widths, ALU opcodes, forwarding selects
// and the ID/EX pipeline slot layout.
package core_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SRL  = 4'b0011;
    localparam logic [3:0] ALU_SRA  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    // All-zero encodes a NOP, so a bubble or flush simply clears the slot.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [3:0]      alu_control;
        logic            src_pc;
        logic            src_imm;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
    } idex_slot_t;

    function automatic logic fwd_hit(input logic [REGW-1:0] idx,
                                     input logic [REGW-1:0] rd,
                                     input logic            we);
        return we && (idx == rd) && (idx != {REGW{1'b0}});
    endfunction

endpackage

// File: rtl/operand_forward.sv
// Per-operand bypass: picks EX/MEM, then MEM/WB, then the register-file value.
// x0 never matches, so a hard-wired zero is never overwritten by a forward.
module operand_forward
    import core_pkg::*;
(
    input  logic [REGW-1:0] i_idx,
    input  logic [XLEN-1:0] i_reg_data,
    input  logic [REGW-1:0] i_exmem_rd,
    input  logic            i_exmem_we,
    input  logic [XLEN-1:0] i_exmem_result,
    input  logic [REGW-1:0] i_memwb_rd,
    input  logic            i_memwb_we,
    input  logic [XLEN-1:0] i_memwb_data,
    output logic [XLEN-1:0] o_data
);

    fwd_sel_e w_sel;

    // Priority select: the younger EX/MEM producer shadows MEM/WB.
    always_comb begin
        w_sel = FWD_REG;
        if (fwd_hit(i_idx, i_exmem_rd, i_exmem_we)) begin
            w_sel = FWD_EXMEM;
        end else if (fwd_hit(i_idx, i_memwb_rd, i_memwb_we)) begin
            w_sel = FWD_MEMWB;
        end else begin
            w_sel = FWD_REG;
        end
    end

    // 3:1 operand mux.
    always_comb begin
        o_data = i_reg_data;
        case (w_sel)
            FWD_EXMEM: o_data = i_exmem_result;
            FWD_MEMWB: o_data = i_memwb_data;
            FWD_REG:   o_data = i_reg_data;
            default:   o_data = i_reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV32I core: latches the decoded slot, inserts
// load-use bubbles, and drives forwarded ALU operands and downstream controls.
module id_ex_stage
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [3:0]      id_alu_control,
    input  logic            id_alu_src_pc,
    input  logic            id_alu_src_imm,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_reg_write,
    input  logic [REGW-1:0] exmem_rd,
    input  logic [REGW-1:0] memwb_rd,
    input  logic            exmem_reg_write,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [XLEN-1:0] memwb_data,
    input  logic            hold,
    input  logic            flush,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [3:0]      ALU_control,
    output logic            ex_valid,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic [REGW-1:0] ex_rd,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_store_data,
    output logic            stall_id
);

    idex_slot_t      r_slot;
    idex_slot_t      w_slot_nxt;
    idex_slot_t      w_capture;
    logic            w_load_use;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    // Load in EX whose destination the decoding instruction reads.
    always_comb begin
        w_load_use = id_valid && r_slot.valid && r_slot.mem_read
                     && (r_slot.rd != {REGW{1'b0}})
                     && ((id_use_rs1 && (id_rs1 == r_slot.rd))
                      || (id_use_rs2 && (id_rs2 == r_slot.rd)));
    end

    // A redirect kills the younger instructions, so it never asks ID to stall.
    always_comb begin
        if (rst || flush) begin
            stall_id = 1'b0;
        end else begin
            stall_id = hold || w_load_use;
        end
    end

    // Pack the ID-side fields into the slot format.
    always_comb begin
        w_capture             = '0;
        w_capture.valid       = id_valid;
        w_capture.pc          = id_pc;
        w_capture.rs1_data    = id_rs1_data;
        w_capture.rs2_data    = id_rs2_data;
        w_capture.imm         = id_imm;
        w_capture.rs1         = id_rs1;
        w_capture.rs2         = id_rs2;
        w_capture.rd          = id_rd;
        w_capture.alu_control = id_alu_control;
        w_capture.src_pc      = id_alu_src_pc;
        w_capture.src_imm     = id_alu_src_imm;
        w_capture.mem_read    = id_mem_read;
        w_capture.mem_write   = id_mem_write;
        w_capture.reg_write   = id_reg_write;
    end

    // Slot update priority: flush, then hold, then bubble, then capture.
    always_comb begin
        w_slot_nxt = r_slot;
        if (flush) begin
            w_slot_nxt = '0;
        end else if (hold) begin
            w_slot_nxt = r_slot;
        end else if (w_load_use) begin
            w_slot_nxt = '0;
        end else begin
            w_slot_nxt = w_capture;
        end
    end

    // Pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
        end else begin
            r_slot <= w_slot_nxt;
        end
    end

    operand_forward u_fwd_rs1 (
        .i_idx          (r_slot.rs1),
        .i_reg_data     (r_slot.rs1_data),
        .i_exmem_rd     (exmem_rd),
        .i_exmem_we     (exmem_reg_write),
        .i_exmem_result (exmem_result),
        .i_memwb_rd     (memwb_rd),
        .i_memwb_we     (memwb_reg_write),
        .i_memwb_data   (memwb_data),
        .o_data         (w_fwd_rs1)
    );

    operand_forward u_fwd_rs2 (
        .i_idx          (r_slot.rs2),
        .i_reg_data     (r_slot.rs2_data),
        .i_exmem_rd     (exmem_rd),
        .i_exmem_we     (exmem_reg_write),
        .i_exmem_result (exmem_result),
        .i_memwb_rd     (memwb_rd),
        .i_memwb_we     (memwb_reg_write),
        .i_memwb_data   (memwb_data),
        .o_data         (w_fwd_rs2)
    );

    // ALU operands; stores always carry the forwarded rs2 even when B is the immediate.
    always_comb begin
        A             = r_slot.src_pc  ? r_slot.pc  : w_fwd_rs1;
        B             = r_slot.src_imm ? r_slot.imm : w_fwd_rs2;
        ex_store_data = w_fwd_rs2;
        ALU_control   = r_slot.alu_control;
        ex_valid      = r_slot.valid;
        ex_mem_read   = r_slot.valid && r_slot.mem_read;
        ex_mem_write  = r_slot.valid && r_slot.mem_write;
        ex_reg_write  = r_slot.valid && r_slot.reg_write;
        ex_rd         = r_slot.rd;
        ex_pc         = r_slot.pc;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: stimulus pushes hand-computed
// expectations, a monitor pops and compares them against the DUT outputs.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [3:0]  id_alu_control;
    logic        id_alu_src_pc, id_alu_src_imm;
    logic        id_mem_read, id_mem_write, id_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_result, memwb_data;
    logic        hold, flush;
    logic [31:0] A, B;
    logic [3:0]  ALU_control;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [4:0]  ex_rd;
    logic [31:0] ex_pc, ex_store_data;
    logic        stall_id;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_alu_control(id_alu_control), .id_alu_src_pc(id_alu_src_pc),
        .id_alu_src_imm(id_alu_src_imm), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
        .exmem_result(exmem_result), .memwb_data(memwb_data),
        .hold(hold), .flush(flush), .A(A), .B(B), .ALU_control(ALU_control),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .ex_pc(ex_pc),
        .ex_store_data(ex_store_data), .stall_id(stall_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] a, b, sd, pc;
        logic [3:0]  alu;
        logic        v, mr, mw, rw;
        logic [4:0]  rd;
        logic        st;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    event chk_ev;

    task automatic push(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] sd, input logic [3:0] alu, input logic v,
                        input logic mr, input logic mw, input logic rw, input logic [4:0] rd,
                        input logic [31:0] pc, input logic st);
        exp_t e;
        e.nm = nm; e.a = a; e.b = b; e.sd = sd; e.alu = alu; e.v = v;
        e.mr = mr; e.mw = mw; e.rw = rw; e.rd = rd; e.pc = pc; e.st = st;
        q.push_back(e);
    endtask

    task automatic push_nop(input string nm, input logic st);
        push(nm, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, st);
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm, input logic u1,
                          input logic u2, input logic [3:0] alu, input logic spc,
                          input logic simm, input logic mr, input logic mw, input logic rw);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_use_rs1 = u1;
        id_use_rs2 = u2; id_alu_control = alu; id_alu_src_pc = spc;
        id_alu_src_imm = simm; id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
    endtask

    task automatic set_fwd(input logic [4:0] xrd, input logic xwe, input logic [31:0] xres,
                           input logic [4:0] wrd, input logic wwe, input logic [31:0] wdat);
        exmem_rd = xrd; exmem_reg_write = xwe; exmem_result = xres;
        memwb_rd = wrd; memwb_reg_write = wwe; memwb_data = wdat;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every queued expectation when outputs are sampled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if ({A, B, ex_store_data, ALU_control, ex_valid, ex_mem_read, ex_mem_write,
                     ex_reg_write, ex_rd, ex_pc, stall_id} !==
                    {e.a, e.b, e.sd, e.alu, e.v, e.mr, e.mw, e.rw, e.rd, e.pc, e.st}) begin
                    n_fail++;
                    $display("FAIL %s: got A=%h B=%h sd=%h alu=%h v=%b mr=%b mw=%b rw=%b rd=%0d pc=%h st=%b | required A=%h B=%h sd=%h alu=%h v=%b mr=%b mw=%b rw=%b rd=%0d pc=%h st=%b",
                             e.nm, A, B, ex_store_data, ALU_control, ex_valid, ex_mem_read,
                             ex_mem_write, ex_reg_write, ex_rd, ex_pc, stall_id,
                             e.a, e.b, e.sd, e.alu, e.v, e.mr, e.mw, e.rw, e.rd, e.pc, e.st);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; hold = 1'b1; flush = 1'b0;
        set_id(1'b1, 32'h50, 5'd1, 5'd2, 5'd3, 32'h9, 32'h9, 32'h9, 1'b1, 1'b1,
               4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        set_fwd(5'd1, 1'b1, 32'hAA, 5'd2, 1'b1, 32'hBB);
        step();
        push_nop("reset_state", 1'b0);
        step();
        rst = 1'b0; hold = 1'b0;
        set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        // ADD x5 = x1 + x2
        set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 32'h0, 1'b1, 1'b1,
               4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push_nop("idle_after_rst", 1'b0);
        step();
        push("add_capture", 32'd5, 32'd7, 32'd7, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h100, 1'b0);
        set_id(1'b1, 32'h104, 5'd3, 5'd0, 5'd6, 32'h11, 32'h22, 32'h0, 1'b1, 1'b1,
               4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        set_fwd(5'd3, 1'b1, 32'h10, 5'd3, 1'b1, 32'h20);
        push("fwd_exmem_prio", 32'h10, 32'h22, 32'h22, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 32'h104, 1'b0);
        set_id(1'b1, 32'h108, 5'd0, 5'd0, 5'd7, 32'h33, 32'h44, 32'h0, 1'b1, 1'b1,
               4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        set_fwd(5'd0, 1'b1, 32'h10, 5'd0, 1'b1, 32'h20);
        push("x0_not_fwd", 32'h33, 32'h44, 32'h44, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h108, 1'b0);
        // LW x4, 8(x1)
        set_id(1'b1, 32'h10C, 5'd1, 5'd0, 5'd4, 32'h1000, 32'h0, 32'h8, 1'b1, 1'b0,
               4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        // ADD x8 = x4 + x2 depends on the load
        set_id(1'b1, 32'h110, 5'd4, 5'd2, 5'd8, 32'hDEAD, 32'd3, 32'h0, 1'b1, 1'b1,
               4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push("load_use_stall", 32'h1000, 32'h8, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 32'h10C, 1'b1);
        step();
        push_nop("bubble", 1'b0);
        step();
        set_fwd(5'd0, 1'b0, 32'h0, 5'd4, 1'b1, 32'h55);
        push("dep_fwd_memwb", 32'h55, 32'd3, 32'd3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 32'h110, 1'b0);
        // LW x9, 4(x1)
        set_id(1'b1, 32'h114, 5'd1, 5'd0, 5'd9, 32'h2000, 32'h0, 32'h4, 1'b1, 1'b0,
               4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        set_id(1'b1, 32'h118, 5'd0, 5'd9, 5'd10, 32'h0, 32'h1, 32'h0, 1'b1, 1'b1,
               4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        push("flush_no_stall", 32'h2000, 32'h4, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h114, 1'b0);
        step();
        flush = 1'b0;
        push_nop("flushed_slot", 1'b0);
        // XOR x11 = x5 ^ x6
        set_id(1'b1, 32'h200, 5'd5, 5'd6, 5'd11, 32'h40, 32'h60, 32'h0, 1'b1, 1'b1,
               4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        hold = 1'b1;
        set_fwd(5'd5, 1'b1, 32'hA1, 5'd0, 1'b0, 32'h0);
        set_id(1'b1, 32'h204, 5'd1, 5'd2, 5'd0, 32'h999, 32'h888, 32'h0, 1'b1, 1'b1,
               4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push("hold_1", 32'hA1, 32'h60, 32'h60, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 32'h200, 1'b1);
        step();
        exmem_result = 32'hA2;
        id_pc = 32'h208; id_rs1_data = 32'h777;
        push("hold_2", 32'hA2, 32'h60, 32'h60, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 32'h200, 1'b1);
        step();
        set_fwd(5'd5, 1'b1, 32'hA3, 5'd6, 1'b1, 32'hB6);
        push("hold_3", 32'hA3, 32'hB6, 32'hB6, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 32'h200, 1'b1);
        step();
        hold = 1'b0;
        set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        push("hold_release", 32'h40, 32'h60, 32'h60, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 32'h200, 1'b0);
        // SW x7, 16(x1)
        set_id(1'b1, 32'h20C, 5'd1, 5'd7, 5'd0, 32'h500, 32'h77, 32'h10, 1'b1, 1'b1,
               4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        set_fwd(5'd7, 1'b1, 32'h7F, 5'd0, 1'b0, 32'h0);
        push("store_fwd", 32'h500, 32'h10, 32'h7F, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h20C, 1'b0);
        // AUIPC x12, 0x1
        set_id(1'b1, 32'h300, 5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'h1000, 1'b0, 1'b0,
               4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        push("src_pc_imm", 32'h300, 32'h1000, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 32'h300, 1'b0);
        set_id(1'b1, 32'h304, 5'd1, 5'd0, 5'd13, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0,
               4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        set_id(1'b1, 32'h308, 5'd13, 5'd0, 5'd14, 32'h1, 32'h0, 32'h0, 1'b1, 1'b0,
               4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push("load_use_2", 32'h10, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd13, 32'h304, 1'b1);
        step();
        hold = 1'b1;
        #1;
        push_nop("bubble_hold", 1'b1);
        -> chk_ev;
        #1;
        rst = 1'b1;
        #1;
        push_nop("rst_async", 1'b0);
        -> chk_ev;
        step();
        rst = 1'b0; hold = 1'b0;
        set_id(1'b1, 32'h400, 5'd1, 5'd2, 5'd15, 32'h21, 32'h12, 32'h0, 1'b1, 1'b1,
               4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push_nop("post_rst_idle", 1'b0);
        step();
        push("first_capture", 32'h21, 32'h12, 32'h12, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd15, 32'h400, 1'b0);
        id_valid = 1'b0;
        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
